// File: rtl/irq_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module : irq_conditioner_if
// Brief  : Button-in / pause-out signal bundle for irq_conditioner.
// Rev    : 1.0  initial release
// ============================================================================
interface irq_conditioner_if;
    logic       btn_raw;
    logic       irq_ack;
    logic       pause;
    logic       btn_level;
    logic [7:0] irq_count;

    // Board/core side: drives the button and acknowledge, observes the request.
    modport master (
        output btn_raw,
        output irq_ack,
        input  pause,
        input  btn_level,
        input  irq_count
    );

    // Conditioner side.
    modport slave (
        input  btn_raw,
        input  irq_ack,
        output pause,
        output btn_level,
        output irq_count
    );
endinterface
`default_nettype wire

// File: rtl/irq_conditioner.sv
`default_nettype none
// ============================================================================
// Module : irq_conditioner
// Brief  : Synchronise, debounce and latch the interrupt button into a
//          single pause request. Optional press counter: IRQ_COND_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module irq_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    irq_conditioner_if.slave  bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pending;
    logic                   w_sync;
    logic                   w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_accept = (r_state == ST_RISING) && w_sync && (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.btn_raw};
        end
    end

    // Debounce FSM; btn_level is updated on the same edges as the state so it
    // stays a plain register with no decode path to the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                ST_LOW: begin
                    if (w_sync) begin
                        r_state <= ST_RISING;
                        r_cnt   <= '0;
                    end
                end
                ST_RISING: begin
                    if (!w_sync) begin
                        r_state <= ST_LOW;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= ST_HIGH;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!w_sync) begin
                        r_state <= ST_FALLING;
                        r_cnt   <= '0;
                    end
                end
                ST_FALLING: begin
                    if (w_sync) begin
                        r_state <= ST_HIGH;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= ST_LOW;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    // A new press takes priority over a coincident acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
        end else if (bus.irq_ack) begin
            r_pending <= 1'b0;
        end
    end

    assign bus.pause     = r_pending;
    assign bus.btn_level = r_level;

`ifdef IRQ_COND_COUNT_EN
    logic [7:0] r_irq_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_count <= 8'h00;
        end else if (w_accept && (r_irq_count != 8'hFF)) begin
            r_irq_count <= r_irq_count + 8'd1;
        end
    end

    assign bus.irq_count = r_irq_count;
`else
    assign bus.irq_count = 8'h00;
`endif

endmodule
`default_nettype wire
